// File: rtl/sine_voice_scheduler.sv
// Scans every voice through one sine BRAM read port per sample tick and sums the gated samples.
// Optional build macro SINE_VOICE_SCHED_NORM_EN scales the mix by the active-voice count.
module sine_voice_scheduler #(
  parameter int NUM_VOICES   = 8,
  parameter int PHASE_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  localparam int IDX_WIDTH   = $clog2(NUM_VOICES),
  localparam int MIX_WIDTH   = DATA_WIDTH + IDX_WIDTH,
  localparam int CNT_WIDTH   = IDX_WIDTH + 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   sample_tick_in,
  input  logic [NUM_VOICES-1:0]  gate_in,
  input  logic [PHASE_WIDTH-1:0] phase_in [NUM_VOICES],
  output logic [ADDR_WIDTH-1:0]  addr_out,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [MIX_WIDTH-1:0]   mix_out,
  output logic [CNT_WIDTH-1:0]   active_count_out,
  output logic                   mix_valid_out,
  output logic                   busy_out,
  output logic                   overrun_out
);

  localparam int DRN_WIDTH = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_VOICES - 1);
  // One extra drain cycle lets the final accumulation settle before the output register loads.
  localparam logic [DRN_WIDTH-1:0] DRAIN_LAST = DRN_WIDTH'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   tick_accept_s;
  logic                   tick_overrun_s;
  logic                   tag_push_s;
  logic                   unused_phase_s;
  logic [IDX_WIDTH-1:0]   idx_r;
  logic [DRN_WIDTH-1:0]   drain_r;
  logic [NUM_VOICES-1:0]  snap_gate_r;
  logic [ADDR_WIDTH-1:0]  snap_addr_r [NUM_VOICES];
  logic [READ_LATENCY-1:0] tag_r;
  logic [MIX_WIDTH-1:0]   acc_r;
  logic [CNT_WIDTH-1:0]   cnt_r;

`ifdef SINE_VOICE_SCHED_NORM_EN
  function automatic logic [MIX_WIDTH-1:0] mix_result(input logic [MIX_WIDTH-1:0] sum,
                                                      input logic [CNT_WIDTH-1:0] cnt);
    int unsigned sh;
    sh = 0;
    for (int s = CNT_WIDTH; s >= 0; s--) begin
      if ((32'd1 << s) >= 32'(cnt)) begin
        sh = s;
      end else begin
        sh = sh;
      end
    end
    return sum >> sh;
  endfunction
`else
  function automatic logic [MIX_WIDTH-1:0] mix_result(input logic [MIX_WIDTH-1:0] sum,
                                                      input logic [CNT_WIDTH-1:0] cnt);
    logic unused_cnt;
    unused_cnt = ^cnt;
    return sum;
  endfunction
`endif

  // Next-state and tick classification
  always_comb begin
    state_nxt_s    = state_r;
    tick_accept_s  = 1'b0;
    tick_overrun_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sample_tick_in) begin
          state_nxt_s   = ISSUE;
          tick_accept_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    if (sample_tick_in && (state_r != IDLE)) begin
      tick_overrun_s = 1'b1;
    end else begin
      tick_overrun_s = 1'b0;
    end
    if (state_r == ISSUE) begin
      tag_push_s = snap_gate_r[idx_r];
    end else begin
      tag_push_s = 1'b0;
    end
    unused_phase_s = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      unused_phase_s = unused_phase_s ^ (^phase_in[i]);
    end
  end

  // FSM state, snapshot capture, address sequencing and status flags
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      drain_r     <= '0;
      snap_gate_r <= '0;
      for (int i = 0; i < NUM_VOICES; i++) snap_addr_r[i] <= '0;
      addr_out    <= '0;
      busy_out    <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      busy_out <= (state_nxt_s != IDLE);
      if (tick_overrun_s) overrun_out <= 1'b1;
      case (state_r)
        IDLE: begin
          if (tick_accept_s) begin
            snap_gate_r <= gate_in;
            for (int i = 0; i < NUM_VOICES; i++) begin
              snap_addr_r[i] <= phase_in[i][PHASE_WIDTH-1 -: ADDR_WIDTH];
            end
            // Voice 0 must be on the bus in the very next cycle, so bypass the snapshot.
            addr_out <= phase_in[0][PHASE_WIDTH-1 -: ADDR_WIDTH];
            idx_r    <= '0;
            drain_r  <= '0;
          end
        end
        ISSUE: begin
          if (idx_r != IDX_LAST) begin
            addr_out <= snap_addr_r[IDX_WIDTH'(idx_r + 1'b1)];
            idx_r    <= IDX_WIDTH'(idx_r + 1'b1);
          end
        end
        DRAIN:   drain_r <= DRN_WIDTH'(drain_r + 1'b1);
        DONE:    drain_r <= '0;
        default: drain_r <= '0;
      endcase
    end
  end

  // Gate-tag pipeline aligned with the BRAM read latency
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tag_r <= '0;
    end else begin
      tag_r[0] <= tag_push_s;
      for (int i = 1; i < READ_LATENCY; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  // Accumulator and active-voice counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (tick_accept_s) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (tag_r[READ_LATENCY-1]) begin
      acc_r <= acc_r + MIX_WIDTH'(data_in);
      cnt_r <= cnt_r + CNT_WIDTH'(1);
    end
  end

  // Result registers loaded on the DRAIN-to-DONE transition
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mix_out          <= '0;
      active_count_out <= '0;
      mix_valid_out    <= 1'b0;
    end else begin
      mix_valid_out <= (state_r == DRAIN) && (state_nxt_s == DONE);
      if ((state_r == DRAIN) && (state_nxt_s == DONE)) begin
        mix_out          <= mix_result(acc_r, cnt_r);
        active_count_out <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Randomized self-checking bench for sine_voice_scheduler against a per-scan reference model.
module tb_sine_voice_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sample_tick_in;
  logic [7:0]  gate_in;
  logic [31:0] phase_in [8];
  logic [7:0]  addr_out;
  logic [7:0]  data_in;
  logic [10:0] mix_out;
  logic [3:0]  active_count_out;
  logic        mix_valid_out;
  logic        busy_out;
  logic        overrun_out;

  logic [7:0]  mem [256];
  logic [7:0]  bram_d1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_mix  = '0;
  logic [31:0] exp_cnt  = '0;
  logic [31:0] exp_addr = '0;
  logic        exp_ovr  = 1'b0;

  sine_voice_scheduler dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_tick_in   (sample_tick_in),
    .gate_in          (gate_in),
    .phase_in         (phase_in),
    .addr_out         (addr_out),
    .data_in          (data_in),
    .mix_out          (mix_out),
    .active_count_out (active_count_out),
    .mix_valid_out    (mix_valid_out),
    .busy_out         (busy_out),
    .overrun_out      (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle registered BRAM
  always @(posedge clk_in) begin
    bram_d1 <= mem[addr_out];
    data_in <= bram_d1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where, input logic exp_busy, input logic exp_valid);
    check_eq({where, " addr"},  32'(addr_out), exp_addr);
    check_eq({where, " mix"},   32'(mix_out), exp_mix);
    check_eq({where, " count"}, 32'(active_count_out), exp_cnt);
    check_eq({where, " valid"}, 32'(mix_valid_out), 32'(exp_valid));
    check_eq({where, " busy"},  32'(busy_out), 32'(exp_busy));
    check_eq({where, " ovr"},   32'(overrun_out), 32'(exp_ovr));
  endtask

  // One scan: tick at relative cycle 0, optional extra tick at ovr_at, optional reset at rst_at.
  task automatic do_scan(input logic [7:0] g, input int ovr_at, input int rst_at);
    logic [7:0] ea [8];
    int sum, cnt, sh, want_mix;
    logic aborted;
    sum = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ea[i] = phase_in[i][31:24];
      if (g[i]) begin
        sum += int'(mem[ea[i]]);
        cnt++;
      end
    end
`ifdef SINE_VOICE_SCHED_NORM_EN
    sh = 0;
    while ((1 << sh) < cnt) sh++;
    want_mix = sum >> sh;
`else
    sh = 0;
    want_mix = sum;
`endif
    aborted = 1'b0;
    @(negedge clk_in);
    check_outputs("idle", 1'b0, 1'b0);
    gate_in        = g;
    sample_tick_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_in);
      sample_tick_in = 1'b0;
      rst_in         = 1'b0;
      gate_in        = 8'($urandom);
      for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
      if (rst_at > 0 && k == rst_at + 1) aborted = 1'b1;
      if (aborted) begin
        exp_ovr  = 1'b0;
        exp_mix  = '0;
        exp_cnt  = '0;
        exp_addr = '0;
        check_outputs($sformatf("rst k=%0d", k), 1'b0, 1'b0);
      end else begin
        if (k <= 8) exp_addr = 32'(ea[k-1]);
        if (k == 12) begin
          exp_mix = 32'(want_mix);
          exp_cnt = 32'(cnt);
        end
        if (ovr_at > 0 && k == ovr_at + 1) exp_ovr = 1'b1;
        check_outputs($sformatf("scan k=%0d", k), (k <= 12), (k == 12));
      end
      if (k == ovr_at) sample_tick_in = 1'b1;
      if (k == rst_at) rst_in = 1'b1;
    end
  endtask

  initial begin
    rst_in         = 1'b1;
    sample_tick_in = 1'b0;
    gate_in        = '0;
    for (int i = 0; i < 8; i++) phase_in[i] = '0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a + 1);
    repeat (2) @(negedge clk_in);
    check_outputs("reset", 1'b0, 1'b0);
    rst_in = 1'b0;

    // Single voice, BRAM returns addr+1
    for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
    phase_in[0] = 32'h4000_0000;
    do_scan(8'h01, 0, 0);

    // Two voices: 100 + 200
    mem[8'h10] = 8'd100;
    mem[8'h20] = 8'd200;
    for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
    phase_in[0] = 32'h1012_3456;
    phase_in[7] = 32'h20AB_CDEF;
    do_scan(8'h81, 0, 0);

    // All voices gated at full scale
    for (int i = 0; i < 8; i++) begin
      phase_in[i] = {8'(8'hC0 + i), 24'($urandom)};
      mem[8'hC0 + i] = 8'd255;
    end
    do_scan(8'hFF, 0, 0);

    // Silence still sweeps addresses and pulses valid
    for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
    do_scan(8'h00, 0, 0);

    // Overrun tick at t+5, then a normal scan at t+15
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
    do_scan(8'($urandom), 5, 0);
    for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
    do_scan(8'($urandom), 0, 0);

    // Reset mid-scan, then a clean scan
    for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
    do_scan(8'hFF, 0, 6);
    for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
    do_scan(8'($urandom), 0, 0);

    // Randomized scans with occasional overruns and resets
    for (int n = 0; n < 24; n++) begin
      int ov, rs;
      ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
      rs = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 13)) : 0;
      for (int i = 0; i < 8; i++) phase_in[i] = $urandom;
      do_scan(8'($urandom), ov, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
